tcam_reg_rd_resp: RTL

Register read-back responder for the TCAM subsystem, serving the `i_switch_reg_bus_rd` / `o_switch_reg_bus_we_dout` side of the switch register bus. It returns TCAM status and error counters, and lookup statistics when compiled in. It also reads any action-table entry through an indexed window, sharing the action BRAM read port with the lookup path and always yielding that port to lookups. It sits beside the write/ack manager in the TCAM top level, between the register bus and the action BRAM port B.

---
 rtl/tcam_pkg.sv | 32 +++
 rtl/tcam_reg_rd_resp_if.sv | 34 +++
 rtl/sat_cnt16.sv | 22 ++
 rtl/tcam_reg_rd_resp.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared TCAM definitions: register-read address map, read-back FSM states
// and a constant-evaluable clog2.
package tcam_pkg;

    localparam int unsigned TCAM_RA_STATUS     = 32'h00;
    localparam int unsigned TCAM_RA_RD_INDEX   = 32'h01;
    localparam int unsigned TCAM_RA_ACT_LO     = 32'h02;
    localparam int unsigned TCAM_RA_ACT_HI     = 32'h03;
    localparam int unsigned TCAM_RA_LOOKUP_CNT = 32'h04;
    localparam int unsigned TCAM_RA_HIT_CNT    = 32'h05;
    localparam int unsigned TCAM_RA_ERR_CNT    = 32'h06;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } tcam_rd_state_e;

    function automatic int unsigned tcam_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tcam_reg_rd_resp_if.sv
// Switch register bus as seen by the TCAM read-back responder. The bus master
// issues read/write strobes; the responder (slave) returns read data.
interface tcam_reg_rd_resp_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              switch_reg_bus_rd;
    logic [ADDR_W-1:0] switch_reg_bus_rd_addr;
    logic              switch_reg_bus_we;
    logic [ADDR_W-1:0] switch_reg_bus_we_addr;
    logic [DATA_W-1:0] switch_reg_bus_we_din;
    logic [DATA_W-1:0] switch_reg_bus_we_dout;
    logic              switch_reg_bus_we_dout_v;

    modport master (
        output switch_reg_bus_rd,
        output switch_reg_bus_rd_addr,
        output switch_reg_bus_we,
        output switch_reg_bus_we_addr,
        output switch_reg_bus_we_din,
        input  switch_reg_bus_we_dout,
        input  switch_reg_bus_we_dout_v
    );

    modport slave (
        input  switch_reg_bus_rd,
        input  switch_reg_bus_rd_addr,
        input  switch_reg_bus_we,
        input  switch_reg_bus_we_addr,
        input  switch_reg_bus_we_din,
        output switch_reg_bus_we_dout,
        output switch_reg_bus_we_dout_v
    );
endinterface

// File: rtl/sat_cnt16.sv
// 16-bit saturating event counter; a clear in the same cycle as an increment
// wins.
module sat_cnt16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);
    logic [15:0] r_cnt;

    // Count up, sticking at all-ones; clear has priority over increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/tcam_reg_rd_resp.sv
// TCAM register read-back responder. Serves status/counter registers directly
// and action-table entries through an indexed window on action BRAM port B,
// always yielding that port to the lookup path.
// Build option: define TCAM_RD_STAT_CNT_EN to add LOOKUP_CNT/HIT_CNT at
// 0x04/0x05; otherwise those addresses read as unmapped.
module tcam_reg_rd_resp
    import tcam_pkg::*;
#(
    parameter int unsigned REG_ADDR_BUS_WIDTH = 8,
    parameter int unsigned REG_DATA_BUS_WIDTH = 16,
    parameter int unsigned ACTION_WIDTH       = 24,
    parameter int unsigned CAM_NUM            = 1024,
    localparam int unsigned AW                = tcam_clog2(CAM_NUM)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    tcam_reg_rd_resp_if.slave       reg_bus,
    input  logic                    i_switch_err_cnt_clr,
    input  logic                    i_tcam_busy,
    input  logic [3:0]              i_fsm_state,
    input  logic                    i_look_up_data_vld,
    input  logic                    i_acl_vld,
    output logic                    o_ram_rd_en,
    output logic [AW-1:0]           o_ram_rd_addr,
    input  logic [ACTION_WIDTH-1:0] i_ram_dout,
    output logic                    o_rd_busy
);
    localparam int unsigned DW = REG_DATA_BUS_WIDTH;

    typedef logic [REG_ADDR_BUS_WIDTH-1:0] addr_t;

    localparam addr_t RA_STATUS     = addr_t'(TCAM_RA_STATUS);
    localparam addr_t RA_RD_INDEX   = addr_t'(TCAM_RA_RD_INDEX);
    localparam addr_t RA_ACT_LO     = addr_t'(TCAM_RA_ACT_LO);
    localparam addr_t RA_ACT_HI     = addr_t'(TCAM_RA_ACT_HI);
    localparam addr_t RA_ERR_CNT    = addr_t'(TCAM_RA_ERR_CNT);
`ifdef TCAM_RD_STAT_CNT_EN
    localparam addr_t RA_LOOKUP_CNT = addr_t'(TCAM_RA_LOOKUP_CNT);
    localparam addr_t RA_HIT_CNT    = addr_t'(TCAM_RA_HIT_CNT);
`endif

    tcam_rd_state_e  r_state;
    logic [AW-1:0]   r_rd_index;
    logic [AW-1:0]   r_ram_rd_addr;
    logic            r_hi_sel;
    logic [DW-1:0]   r_dout;
    logic            r_dout_v;
    logic            r_rd_busy;

    logic            w_rd;
    addr_t           w_rd_addr;
    logic            w_idle;
    logic            w_act_rd;
    logic            w_mapped;
    logic [DW-1:0]   w_dir_data;
    logic [DW-1:0]   w_act_lo;
    logic [DW-1:0]   w_act_hi;
    logic            w_idx_we;
    logic            w_err_inc;
    logic [15:0]     w_err_cnt;
    logic            w_unused;

    assign w_rd      = reg_bus.switch_reg_bus_rd;
    assign w_rd_addr = reg_bus.switch_reg_bus_rd_addr;
    assign w_idle    = (r_state == StIdle);
    assign w_act_rd  = (w_rd_addr == RA_ACT_LO) || (w_rd_addr == RA_ACT_HI);
    assign w_idx_we  = reg_bus.switch_reg_bus_we && (reg_bus.switch_reg_bus_we_addr == RA_RD_INDEX);
    assign w_act_lo  = DW'(i_ram_dout[15:0]);
    assign w_act_hi  = DW'(i_ram_dout >> 16);

    // Only the low AW bits of a RD_INDEX write are kept.
    assign w_unused  = ^reg_bus.switch_reg_bus_we_din;

    // Reads arriving mid-transaction are dropped; unmapped reads still answer 0.
    assign w_err_inc = w_rd && (!w_idle || (!w_act_rd && !w_mapped));

    sat_cnt16 u_err_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_switch_err_cnt_clr),
        .i_inc (w_err_inc),
        .o_cnt (w_err_cnt)
    );

`ifdef TCAM_RD_STAT_CNT_EN
    logic [15:0] w_lookup_cnt;
    logic [15:0] w_hit_cnt;

    sat_cnt16 u_lookup_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_switch_err_cnt_clr),
        .i_inc (i_look_up_data_vld),
        .o_cnt (w_lookup_cnt)
    );

    sat_cnt16 u_hit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_switch_err_cnt_clr),
        .i_inc (i_acl_vld),
        .o_cnt (w_hit_cnt)
    );
`else
    logic w_unused_acl;
    assign w_unused_acl = i_acl_vld;
`endif

    // Direct-register read mux and address decode.
    always_comb begin
        w_dir_data = '0;
        w_mapped   = 1'b1;
        case (w_rd_addr)
            RA_STATUS:   w_dir_data = DW'({8'h00, i_fsm_state, 2'b00, r_rd_busy, i_tcam_busy});
            RA_RD_INDEX: w_dir_data = DW'(r_rd_index);
            RA_ACT_LO,
            RA_ACT_HI:   w_dir_data = '0;
            RA_ERR_CNT:  w_dir_data = DW'(w_err_cnt);
`ifdef TCAM_RD_STAT_CNT_EN
            RA_LOOKUP_CNT: w_dir_data = DW'(w_lookup_cnt);
            RA_HIT_CNT:    w_dir_data = DW'(w_hit_cnt);
`endif
            default:     w_mapped = 1'b0;
        endcase
    end

    // RD_INDEX register, written by snooping bus writes to its address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_index <= '0;
        end else if (w_idx_we) begin
            r_rd_index <= AW'(reg_bus.switch_reg_bus_we_din);
        end
    end

    // Read responder FSM with registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_ram_rd_addr <= '0;
            r_hi_sel      <= 1'b0;
            r_dout        <= '0;
            r_dout_v      <= 1'b0;
            r_rd_busy     <= 1'b0;
        end else begin
            r_dout_v <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_rd) begin
                        if (w_act_rd) begin
                            r_state       <= StReq;
                            r_hi_sel      <= (w_rd_addr == RA_ACT_HI);
                            r_ram_rd_addr <= r_rd_index;
                            r_rd_busy     <= 1'b1;
                        end else begin
                            r_dout   <= w_dir_data;
                            r_dout_v <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    // Lookups own port B; wait as long as they keep it.
                    if (!i_look_up_data_vld) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    r_dout   <= r_hi_sel ? w_act_hi : w_act_lo;
                    r_dout_v <= 1'b1;
                    r_state  <= StResp;
                end
                StResp: begin
                    r_state   <= StIdle;
                    r_rd_busy <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // The enable is the pending request gated by a same-cycle lookup so the
    // lookup path never loses the port.
    assign o_ram_rd_en   = (r_state == StReq) && !i_look_up_data_vld;
    assign o_ram_rd_addr = r_ram_rd_addr;
    assign o_rd_busy     = r_rd_busy;

    assign reg_bus.switch_reg_bus_we_dout   = r_dout;
    assign reg_bus.switch_reg_bus_we_dout_v = r_dout_v;

endmodule
